// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, block type and the forward S-box lookup
// Contents: BLOCK_LENGTH (state/key width), AES_NB (columns per state),
//           FIFO_DEPTH (default output FIFO depth), block_t, sbox().
package aes_pkg;
  localparam int BLOCK_LENGTH = 128;
  localparam int AES_NB = 4;
  localparam int FIFO_DEPTH = 4;
  typedef logic [BLOCK_LENGTH-1:0] block_t;
  // Entry 0 sits in the most significant byte so the table reads in natural order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction
endpackage

// File: rtl/aes_out_fifo.sv
// aes_out_fifo: non-stalling output FIFO with drop detection and sticky overflow
// Ports: clk, rst_n (async active-low), wr_en_i/wr_data_i write side,
//        rd_en_i consumer ready, ovf_clr_i overflow clear, rd_data_o head (0 when empty),
//        valid_o non-empty, count_o occupancy, overflow_o sticky drop flag.
module aes_out_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W = BLOCK_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  input  logic                     ovf_clr_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic rd, wr, drop;
  // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside it.
  always_comb begin
    rd = rd_en_i & (count_q != '0);
    wr = wr_en_i & ((count_q != CNT_FULL) | rd);
    drop = wr_en_i & ~wr;
    rptr_d = rd ? rptr_q + AW'(1) : rptr_q;
    wptr_d = wr ? wptr_q + AW'(1) : wptr_q;
    count_d = (wr & ~rd) ? count_q + (AW+1)'(1) : (rd & ~wr) ? count_q - (AW+1)'(1) : count_q;
    overflow_d = drop | (overflow_q & ~ovf_clr_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  // Storage needs no reset: stale entries are never visible because OUT is gated by occupancy.
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q] <= wr_data_i;
  assign valid_o = count_q != '0;
  assign rd_data_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/key_add.sv
// key_add: AddRoundKey, XOR of state with the round key
// Ports: in_i state, key_i round key, out_o state ^ key.
module key_add
  import aes_pkg::*;
(
  input  block_t in_i,
  input  block_t key_i,
  output block_t out_o
);
  assign out_o = in_i ^ key_i;
endmodule

// File: rtl/shift_rows.sv
// shift_rows: cyclic left shift of state row r by r columns
// Ports: in_i state in, out_o shifted state.
// Byte n of the state (MSB first) is row n%4, column n/4.
module shift_rows
  import aes_pkg::*;
(
  input  block_t in_i,
  output block_t out_o
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    localparam int R = i % AES_NB;
    localparam int C = i / AES_NB;
    localparam int S = AES_NB * ((C + R) % AES_NB) + R;
    assign out_o[127-8*i -: 8] = in_i[127-8*S -: 8];
  end
endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: byte-wise S-box substitution of a 128-bit state
// Ports: in_i state in, out_o substituted state.
module sub_bytes
  import aes_pkg::*;
(
  input  block_t in_i,
  output block_t out_o
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign out_o[8*i +: 8] = sbox(in_i[8*i +: 8]);
  end
endmodule

// File: rtl/final_round_out_buf.sv
// final_round_out_buf: AES-128 round 10 (SubBytes, ShiftRows, AddRoundKey) feeding an output FIFO
// Ports: clk, rst (async active-low), IN/KEY/enable round-9 state and round-10 key,
//        ovf_clr overflow clear, out_ready/out_valid/OUT ciphertext handshake,
//        overflow sticky drop flag, fifo_count occupancy.
// Optional macro BLOCK_COUNT_EN adds blk_count[31:0], a wrapping count of read handshakes.
module final_round_out_buf #(
  parameter int BLOCK_LENGTH = aes_pkg::BLOCK_LENGTH,
  parameter int FIFO_DEPTH = aes_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BLOCK_LENGTH-1:0]       IN,
  input  logic [BLOCK_LENGTH-1:0]       KEY,
  input  logic                          enable,
  input  logic                          ovf_clr,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [BLOCK_LENGTH-1:0]       OUT,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef BLOCK_COUNT_EN
  ,
  output logic [31:0]                   blk_count
`endif
);
  logic [BLOCK_LENGTH-1:0] sub_out, shift_out, round_out;
  sub_bytes u_sub (.in_i(IN), .out_o(sub_out));
  shift_rows u_shift (.in_i(sub_out), .out_o(shift_out));
  key_add u_key (.in_i(shift_out), .key_i(KEY), .out_o(round_out));
  aes_out_fifo #(.DEPTH(FIFO_DEPTH), .W(BLOCK_LENGTH)) u_fifo (
    .clk(clk),
    .rst_n(rst),
    .wr_en_i(enable),
    .wr_data_i(round_out),
    .rd_en_i(out_ready),
    .ovf_clr_i(ovf_clr),
    .rd_data_o(OUT),
    .valid_o(out_valid),
    .count_o(fifo_count),
    .overflow_o(overflow)
  );
`ifdef BLOCK_COUNT_EN
  logic [31:0] blk_count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) blk_count_q <= '0;
    else if (out_valid & out_ready) blk_count_q <= blk_count_q + 32'd1;
  assign blk_count = blk_count_q;
`endif
endmodule

// File: tb/tb_final_round_out_buf.sv
// tb_final_round_out_buf: self-checking bench for final_round_out_buf (optional BLOCK_COUNT_EN)
module tb_final_round_out_buf;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, enable = 0, ovf_clr = 0, out_ready = 0;
  logic [127:0] IN = '0, KEY = '0, OUT;
  logic out_valid, overflow;
  logic [2:0] fifo_count;
`ifdef BLOCK_COUNT_EN
  logic [31:0] blk_count;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb_ref [256];
  logic [127:0] q [$];
  logic m_ovf = 0;
  int m_blk = 0;
  typedef struct { logic en, rdy, clr; int cnt; logic vld, ovf; } vec_t;
  vec_t tbl [18];

  always #5 clk = ~clk;

  final_round_out_buf dut (
    .clk(clk), .rst(rst), .IN(IN), .KEY(KEY), .enable(enable), .ovf_clr(ovf_clr),
    .out_ready(out_ready), .out_valid(out_valid), .OUT(OUT), .overflow(overflow),
    .fifo_count(fifo_count)
`ifdef BLOCK_COUNT_EN
    , .blk_count(blk_count)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] o;
    int r, src;
    for (int i = 0; i < 16; i++) begin
      r = i % 4;
      src = 4 * ((i / 4 + r) % 4) + r;
      o[127-8*i -: 8] = sb_ref[s[127-8*src -: 8]] ^ k[127-8*i -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, advance the queue model by the same edge, then sample after the edge.
  task automatic step(input logic en, input logic rdy, input logic clr,
                      input logic [127:0] d, input logic [127:0] k);
    logic drop;
    enable = en; out_ready = rdy; ovf_clr = clr; IN = d; KEY = k;
    drop = 0;
    if (q.size() != 0 && rdy) begin q.delete(0); m_blk++; end
    if (en) begin
      if (q.size() < DEPTH) q.push_back(ref_round(d, k));
      else drop = 1;
    end
    m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string t);
    chk({t, ".valid"}, 128'(out_valid), 128'(q.size() != 0));
    chk({t, ".count"}, 128'(fifo_count), 128'(q.size()));
    chk({t, ".out"}, OUT, q.size() != 0 ? q[0] : 128'h0);
    chk({t, ".ovf"}, 128'(overflow), 128'(m_ovf));
`ifdef BLOCK_COUNT_EN
    chk({t, ".blk"}, 128'(blk_count), 128'(m_blk));
`endif
  endtask

  task automatic check_cleared(input string t);
    chk({t, ".valid"}, 128'(out_valid), 128'h0);
    chk({t, ".count"}, 128'(fifo_count), 128'h0);
    chk({t, ".out"}, OUT, 128'h0);
    chk({t, ".ovf"}, 128'(overflow), 128'h0);
`ifdef BLOCK_COUNT_EN
    chk({t, ".blk"}, 128'(blk_count), 128'h0);
`endif
  endtask

  initial begin
    // en rdy clr | count valid ovf, starting from an empty FIFO
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1;

    // FIPS-197 C.1 round 10: start state bd6e..89 yields the published ciphertext.
    step(1, 1, 0, 128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("fips.out", OUT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("fips.valid", 128'(out_valid), 128'h1);
    check_model("fips");
    step(0, 1, 0, '0, '0);
    chk("fips.gone", 128'(out_valid), 128'h0);
    check_model("fips_gone");

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].rdy, tbl[i].clr, rnd128(), rnd128());
      chk($sformatf("tbl%0d.count", i), 128'(fifo_count), 128'(tbl[i].cnt));
      chk($sformatf("tbl%0d.valid", i), 128'(out_valid), 128'(tbl[i].vld));
      chk($sformatf("tbl%0d.ovf", i), 128'(overflow), 128'(tbl[i].ovf));
      check_model($sformatf("tbl%0d", i));
    end

    // Random traffic, alternating stall-heavy and drain-heavy windows.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) < ((i % 64) < 32 ? 2 : 6),
           ($urandom % 16) == 0, rnd128(), rnd128());
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-stream with two entries queued.
    repeat (DEPTH + 1) step(0, 1, 1, '0, '0);
    check_model("drain");
    step(1, 0, 0, rnd128(), rnd128());
    step(1, 0, 0, rnd128(), rnd128());
    check_model("two");
    #2 rst = 0;
    #1;
    check_cleared("async_rst");
    q.delete();
    m_ovf = 0;
    m_blk = 0;
    rst = 1;
    step(1, 0, 0, rnd128(), rnd128());
    chk("post_rst.valid", 128'(out_valid), 128'h1);
    check_model("post_rst");
    repeat (5) begin
      step(1, 1, 0, rnd128(), rnd128());
      check_model("after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
